// File: rtl/d_path_pkg.sv
// d_path_pkg: shared types for the pipe_d_path datapath.
// ALU opcodes, default sizes and the default-size EX bundle layout.
package d_path_pkg;

    localparam int N_DEF     = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9
    } alu_op_e;

    // EX-stage bundle at the default sizes
    typedef struct packed {
        logic              valid;
        logic              write_en;
        logic [AW_DEF-1:0] rd;
        alu_op_e           op;
        logic [N_DEF-1:0]  a;
        logic [N_DEF-1:0]  b;
    } ex_stage_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU, (a, b, op) -> (y, zero).
// Shift amounts use the low $clog2(N) bits of b; unknown ops give 0.
module alu_core
    import d_path_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_op_e      op,
    output logic [N-1:0] y,
    output logic         zero
);

    localparam int SW = $clog2(N);

    logic [SW-1:0] sh;

    assign sh   = b[SW-1:0];
    assign zero = (y == '0);

    // Operation select
    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << sh;
            OP_SRL:  y = a >> sh;
            OP_SRA:  y = $unsigned($signed(a) >>> sh);
            OP_SLT:  y = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: y = {{(N-1){1'b0}}, (a < b)};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/pipe_d_path.sv
// pipe_d_path: ISSUE/EX/WB datapath, register file + ALU, valid/ready issue.
// FORWARD_EN defined: EX/WB bypass, never stalls; undefined: RAW stalls issue.
module pipe_d_path
    import d_path_pkg::*;
#(
    parameter  int N     = N_DEF,
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic [AW-1:0] rd,
    input  logic [3:0]    OpCode,
    input  logic          write_en,
    input  logic          use_imm,
    input  logic [N-1:0]  imm,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    output logic [AW-1:0] out_rd,
    output logic          zero_f
);

    typedef struct packed {
        logic          valid;
        logic          write_en;
        logic [AW-1:0] rd;
        alu_op_e       op;
        logic [N-1:0]  a;
        logic [N-1:0]  b;
    } ex_t;

    typedef struct packed {
        logic          valid;
        logic          write_en;
        logic [AW-1:0] rd;
        logic [N-1:0]  data;
        logic          zero;
    } wb_t;

    ex_t          ex_q;
    wb_t          wb_q;
    logic [N-1:0] rf [NREGS];

    logic [N-1:0] alu_y;
    logic         alu_zero;
    logic         fire;
    logic         stall;
    logic         wb_we;
    logic         ex_hit1;
    logic         ex_hit2;
    logic         wb_hit1;
    logic         wb_hit2;
    logic [N-1:0] rf1;
    logic [N-1:0] rf2;
    logic [N-1:0] opa;
    logic [N-1:0] src2;
    logic [N-1:0] opb;

    alu_core #(.N(N)) u_alu (
        .a    (ex_q.a),
        .b    (ex_q.b),
        .op   (ex_q.op),
        .y    (alu_y),
        .zero (alu_zero)
    );

    assign wb_we = wb_q.valid & wb_q.write_en & (wb_q.rd != '0);

    // Producer matches and write-through register reads
    always_comb begin
        ex_hit1 = ex_q.valid & ex_q.write_en
                & (rs1 != '0) & (ex_q.rd == rs1);
        ex_hit2 = ex_q.valid & ex_q.write_en
                & (rs2 != '0) & (ex_q.rd == rs2);
        wb_hit1 = wb_q.valid & wb_q.write_en
                & (rs1 != '0) & (wb_q.rd == rs1);
        wb_hit2 = wb_q.valid & wb_q.write_en
                & (rs2 != '0) & (wb_q.rd == rs2);
        rf1 = rf[rs1];
        if (rs1 == '0)
            rf1 = '0;
        else if (wb_we && (wb_q.rd == rs1))
            rf1 = wb_q.data;
        rf2 = rf[rs2];
        if (rs2 == '0)
            rf2 = '0;
        else if (wb_we && (wb_q.rd == rs2))
            rf2 = wb_q.data;
    end

`ifdef FORWARD_EN
    // Bypass: EX result beats WB result beats the register file
    always_comb begin
        stall = 1'b0;
        opa   = rf1;
        if (wb_hit1)
            opa = wb_q.data;
        if (ex_hit1)
            opa = alu_y;
        src2 = rf2;
        if (wb_hit2)
            src2 = wb_q.data;
        if (ex_hit2)
            src2 = alu_y;
    end
`else
    // Interlock: hold the request while a used source is in flight
    always_comb begin
        stall = in_valid
              & (ex_hit1 | wb_hit1
              | (~use_imm & (ex_hit2 | wb_hit2)));
        opa   = rf1;
        src2  = rf2;
    end
`endif

    assign opb       = use_imm ? imm : src2;
    assign in_ready  = reset & ~stall;
    assign fire      = in_valid & in_ready;
    assign out_valid = wb_q.valid;
    assign out_data  = wb_q.data;
    assign out_rd    = wb_q.rd;
    assign zero_f    = wb_q.zero;

    // Issue -> EX pipeline register; bubble when nothing is accepted
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_q <= '0;
        end else begin
            ex_q.valid <= fire;
            if (fire) begin
                ex_q.write_en <= write_en;
                ex_q.rd       <= rd;
                ex_q.op       <= alu_op_e'(OpCode);
                ex_q.a        <= opa;
                ex_q.b        <= opb;
            end
        end
    end

    // EX -> WB pipeline register
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_q <= '0;
        end else begin
            wb_q.valid    <= ex_q.valid;
            wb_q.write_en <= ex_q.write_en;
            wb_q.rd       <= ex_q.rd;
            wb_q.data     <= alu_y;
            wb_q.zero     <= ex_q.valid & alu_zero;
        end
    end

    // Register file write at the end of WB; reg 0 never written
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else if (wb_we) begin
            rf[wb_q.rd] <= wb_q.data;
        end
    end

endmodule

// File: tb/tb_pipe_d_path.sv
// tb_pipe_d_path: two instances (32x32 and 16x8) against an in-order model.
// Directed literal cases plus randomized issue traffic with resets.
module tb_pipe_d_path;
    import d_path_pkg::*;

`ifdef FORWARD_EN
    localparam int EXP_STALL = 0;
`else
    localparam int EXP_STALL = 2;
`endif

    bit clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        v0, v1;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  opc;
    logic        we, ui;
    logic [31:0] imm;

    logic        rdy0, ov0, zf0;
    logic [31:0] od0;
    logic [4:0]  ord0;
    logic        rdy1, ov1, zf1;
    logic [15:0] od1;
    logic [2:0]  ord1;

    pipe_d_path #(.N(32), .NREGS(32)) u_dut0 (
        .clk(clk), .reset(reset),
        .in_valid(v0), .in_ready(rdy0),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .OpCode(opc), .write_en(we),
        .use_imm(ui), .imm(imm),
        .out_valid(ov0), .out_data(od0),
        .out_rd(ord0), .zero_f(zf0)
    );

    pipe_d_path #(.N(16), .NREGS(8)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_valid(v1), .in_ready(rdy1),
        .rs1(rs1[2:0]), .rs2(rs2[2:0]), .rd(rd[2:0]),
        .OpCode(opc), .write_en(we),
        .use_imm(ui), .imm(imm[15:0]),
        .out_valid(ov1), .out_data(od1),
        .out_rd(ord1), .zero_f(zf1)
    );

    typedef struct {
        bit              v;
        bit              we;
        int              rd;
        longint unsigned data;
        bit              hl;
        longint unsigned lit;
        bit              rst;
    } ent_t;

    int              checks   = 0;
    int              failures = 0;
    int              nw [2]   = '{32, 16};
    int              nr [2]   = '{32, 8};
    longint unsigned arf [2][32];
    ent_t            e1 [2];
    ent_t            e2 [2];
    bit              exp_rdy [2];
    bit              lit_en;
    longint unsigned lit_v [2];

    task automatic chk(input string nm, input int d,
                       input longint unsigned act,
                       input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t act=%0h exp=%0h",
                     nm, d, $time, act, exp);
        end
    endtask

    function automatic longint unsigned alu_m(
        input int op, input longint unsigned a,
        input longint unsigned b, input int n);
        longint unsigned m;
        longint          sa, sb;
        int              sh;
        m  = (64'd1 << n) - 64'd1;
        sh = int'(b % longint'(n));
        sa = ((a >> (n - 1)) & 1) != 0 ? longint'(a | ~m) : longint'(a);
        sb = ((b >> (n - 1)) & 1) != 0 ? longint'(b | ~m) : longint'(b);
        case (op)
            0: return (a + b) & m;
            1: return (a - b) & m;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return (a << sh) & m;
            6: return a >> sh;
            7: return longint'(sa >>> sh) & m;
            8: return (sa < sb) ? 1 : 0;
            9: return (a < b) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic bit hit(input int d, input int s);
        if (s == 0) return 1'b0;
        return (e1[d].v && e1[d].we && e1[d].rd == s)
            || (e2[d].v && e2[d].we && e2[d].rd == s);
    endfunction

    // Model: architectural effect at acceptance, result visible two edges later
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                for (int i = 0; i < 32; i++) arf[d][i] = 0;
                e1[d] = '{default: 0};
                e2[d] = '{default: 0};
                e2[d].rst = 1'b1;
            end else begin
                e2[d] = e1[d];
                e1[d] = '{default: 0};
                if ((d == 0 ? v0 : v1) && exp_rdy[d]) begin
                    longint unsigned m, a, b, y;
                    int ra, rb, rw;
                    m  = (64'd1 << nw[d]) - 64'd1;
                    ra = int'(rs1) % nr[d];
                    rb = int'(rs2) % nr[d];
                    rw = int'(rd) % nr[d];
                    a  = (ra == 0) ? 0 : arf[d][ra];
                    b  = ui ? (longint'(imm) & m)
                            : ((rb == 0) ? 0 : arf[d][rb]);
                    y  = alu_m(int'(opc), a, b, nw[d]);
                    e1[d].v    = 1'b1;
                    e1[d].we   = we;
                    e1[d].rd   = rw;
                    e1[d].data = y;
                    e1[d].hl   = lit_en;
                    e1[d].lit  = lit_v[d];
                    if (we && rw != 0) arf[d][rw] = y;
                end
            end
        end
    end

    // Compare every cycle, away from the clock edge
    always @(negedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            bit              vin, rdy, ovv, zfv;
            longint unsigned odv;
            int              orv, ra, rb;
            vin = (d == 0) ? v0 : v1;
            rdy = (d == 0) ? rdy0 : rdy1;
            ovv = (d == 0) ? ov0 : ov1;
            zfv = (d == 0) ? zf0 : zf1;
            odv = (d == 0) ? longint'(od0) : longint'(od1);
            orv = (d == 0) ? int'(ord0) : int'(ord1);
            ra  = int'(rs1) % nr[d];
            rb  = int'(rs2) % nr[d];
`ifdef FORWARD_EN
            exp_rdy[d] = reset;
`else
            exp_rdy[d] = reset && !(vin && (hit(d, ra)
                       || (!ui && hit(d, rb))));
`endif
            if (reset && vin)
                chk("in_ready", d, rdy, exp_rdy[d]);
            chk("out_valid", d, ovv, e2[d].v);
            chk("zero_f", d, zfv, e2[d].v && e2[d].data == 0);
            if (e2[d].v) begin
                chk("out_data", d, odv, e2[d].data);
                chk("out_rd", d, orv, e2[d].rd);
                if (e2[d].hl)
                    chk("literal", d, odv, e2[d].lit);
            end
            if (e2[d].rst) begin
                chk("rst_data", d, odv, 0);
                chk("rst_rd", d, orv, 0);
            end
        end
    end

    task automatic randomize_fields();
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        rd  = 5'($urandom_range(0, 31));
        opc = 4'($urandom_range(0, 15));
        we  = 1'($urandom_range(0, 1));
        ui  = 1'($urandom_range(0, 1));
        imm = $urandom;
    endtask

    task automatic idle(input int n);
        v0 = 1'b0;
        v1 = 1'b0;
        randomize_fields();
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        v0 = 1'b0;
        v1 = 1'b0;
        reset = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic issue(input int op, input int a, input int b,
                         input int w, input bit wen, input bit uim,
                         input longint unsigned iv, input bit hl,
                         input longint unsigned l0,
                         input longint unsigned l1,
                         output int st);
        bit a0, a1;
        opc = 4'(op);
        rs1 = 5'(a);
        rs2 = 5'(b);
        rd  = 5'(w);
        we  = wen;
        ui  = uim;
        imm = 32'(iv);
        lit_en   = hl;
        lit_v[0] = l0;
        lit_v[1] = l1;
        v0 = 1'b1;
        v1 = 1'b1;
        st = 0;
        for (int c = 0; c < 10; c++) begin
            if (!v0 && !v1) break;
            #3;
            a0 = v0 && rdy0;
            a1 = v1 && rdy1;
            if (v0 && !rdy0) st++;
            @(negedge clk);
            if (a0) v0 = 1'b0;
            if (a1) v1 = 1'b0;
        end
        if (v0 || v1) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout t=%0t act=pending exp=accepted",
                     $time);
            v0 = 1'b0;
            v1 = 1'b0;
        end
        lit_en = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        reset  = 1'b0;
        v0     = 1'b0;
        v1     = 1'b0;
        lit_en = 1'b0;
        lit_v  = '{0, 0};
        randomize_fields();

        chk("model_add_wrap", 0, alu_m(0, 32'hFFFFFFFF, 1, 32), 0);
        chk("model_sra", 0, alu_m(7, 32'h80000000, 31, 32), 32'hFFFFFFFF);
        chk("model_slt", 0, alu_m(8, 32'hFFFFFFFF, 1, 32), 1);
        chk("model_sltu", 0, alu_m(9, 32'hFFFFFFFF, 1, 32), 0);
        chk("model_sra16", 1, alu_m(7, 16'h8000, 31, 16), 16'hFFFF);

        repeat (2) @(negedge clk);
        reset = 1'b1;
        #3;
        chk("ready_after_reset", 0, rdy0, 1);
        chk("ready_after_reset", 1, rdy1, 1);
        @(negedge clk);

        issue(0, 0, 0, 1, 1, 1, 7, 1, 7, 7, st);

        issue(0, 0, 0, 1, 1, 1, 5, 1, 5, 5, st);
        issue(0, 1, 1, 2, 1, 0, 0, 1, 10, 10, st);
        chk("stall_r2", 0, st, EXP_STALL);
        issue(1, 2, 1, 3, 1, 0, 0, 1, 5, 5, st);
        chk("stall_r3", 0, st, EXP_STALL);

        issue(0, 0, 0, 1, 1, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 16'hFFFF, st);
        issue(0, 1, 0, 2, 1, 1, 1, 1, 0, 0, st);
        issue(0, 0, 0, 1, 1, 1, 32'h80008000, 1, 32'h80008000, 16'h8000, st);
        issue(7, 1, 0, 2, 1, 1, 31, 1, 32'hFFFFFFFF, 16'hFFFF, st);
        issue(0, 0, 0, 1, 1, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 16'hFFFF, st);
        issue(8, 1, 0, 2, 1, 1, 1, 1, 1, 1, st);
        issue(9, 1, 0, 2, 1, 1, 1, 1, 0, 0, st);
        issue(12, 1, 0, 2, 1, 1, 5, 1, 0, 0, st);

        issue(0, 0, 0, 0, 1, 1, 9, 1, 9, 9, st);
        issue(0, 0, 0, 4, 1, 1, 0, 1, 0, 0, st);

        issue(0, 0, 0, 5, 1, 1, 32'h55, 1, 32'h55, 32'h55, st);
        idle(4);
        do_reset(2);
        idle(1);
        issue(0, 5, 0, 6, 1, 1, 0, 1, 0, 0, st);

        issue(0, 0, 0, 3, 1, 1, 32'h33, 1, 32'h33, 32'h33, st);
        issue(0, 3, 0, 7, 1, 1, 1, 1, 32'h34, 32'h34, st);
        do_reset(1);
        idle(1);
        issue(0, 3, 0, 2, 1, 1, 0, 1, 0, 0, st);
        issue(0, 7, 0, 2, 1, 1, 0, 1, 0, 0, st);
        idle(3);

        for (int i = 0; i < 300; i++) begin
            int a, b, w;
            longint unsigned iv;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            if (i == 150) do_reset(1);
            a  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7)
                                             : $urandom_range(0, 31);
            b  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7)
                                             : $urandom_range(0, 31);
            w  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7)
                                             : $urandom_range(0, 31);
            iv = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40)
                                             : $urandom;
            issue($urandom_range(0, 15), a, b, w,
                  $urandom_range(0, 7) != 0, $urandom_range(0, 1),
                  iv, 0, 0, 0, st);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
